// File: rtl/stmm_seq_ctrl.sv
// Command-level sequencer for the StMM execution unit.
// Accepts one command at a time, pulses the parameter fetcher and the StMM core,
// owns the weight-BRAM port select, tracks weight validity and reports a single
// response per command. A per-phase watchdog bounds every wait phase.
module stmm_seq_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_base_addr,
  output logic              fetch_start,
  output logic [ADDR_W-1:0] fetch_base_addr,
  input  logic              fetch_done,
  output logic              exec_start,
  input  logic              exec_done,
  output logic              bram_sel,
  output logic              w_loaded,
  output logic              busy,
  output logic              rsp_valid,
  output logic [1:0]        rsp_err
);

  // A disabled watchdog (TIMEOUT=0) would give a zero-width counter; keep at least one bit.
  localparam int CW = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_FETCH = 2'b01;
  localparam logic [1:0] OP_EXEC  = 2'b10;
  localparam logic [1:0] OP_FX    = 2'b11;

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_NO_W   = 2'b01;
  localparam logic [1:0] ERR_F_TMO  = 2'b10;
  localparam logic [1:0] ERR_X_TMO  = 2'b11;

  typedef enum logic [2:0] {
    IDLE, F_START, F_WAIT, X_START, X_WAIT, RSP
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        op_reg, op_next;
  logic              w_loaded_reg, w_loaded_next;
  logic [1:0]        err_next;
  logic [CW-1:0]     cnt_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              cmd_ready_reg, fetch_start_reg, exec_start_reg;
  logic              bram_sel_reg, busy_reg, rsp_valid_reg;
  logic [1:0]        rsp_err_reg;
  logic              accept, timeout;

  assign accept  = cmd_valid && cmd_ready_reg;
  assign timeout = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  // Next-state, op latch, weight-valid flag and response code selection.
  always_comb begin
    state_next    = state_reg;
    op_next       = op_reg;
    w_loaded_next = w_loaded_reg;
    err_next      = ERR_OK;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          op_next = cmd_op;
          case (cmd_op)
            OP_NOP: state_next = RSP;
            OP_FETCH, OP_FX: begin
              w_loaded_next = 1'b0;
              state_next    = F_START;
            end
            default: begin  // OP_EXEC
              if (w_loaded_reg) begin
                state_next = X_START;
              end else begin
                state_next = RSP;
                err_next   = ERR_NO_W;
              end
            end
          endcase
        end
      end
      F_START, F_WAIT: begin
        // Completion takes priority over a watchdog expiry in the same cycle.
        if (fetch_done) begin
          w_loaded_next = 1'b1;
          state_next    = (op_reg == OP_FX) ? X_START : RSP;
        end else if (timeout) begin
          state_next = RSP;
          err_next   = ERR_F_TMO;
        end else begin
          state_next = F_WAIT;
        end
      end
      X_START, X_WAIT: begin
        if (exec_done) begin
          state_next = RSP;
        end else if (timeout) begin
          state_next = RSP;
          err_next   = ERR_X_TMO;
        end else begin
          state_next = X_WAIT;
        end
      end
      RSP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, latches, watchdog counter and registered Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      op_reg          <= OP_NOP;
      w_loaded_reg    <= 1'b0;
      cnt_reg         <= '0;
      addr_reg        <= '0;
      cmd_ready_reg   <= 1'b0;
      fetch_start_reg <= 1'b0;
      exec_start_reg  <= 1'b0;
      bram_sel_reg    <= 1'b0;
      busy_reg        <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_err_reg     <= ERR_OK;
    end else begin
      state_reg    <= state_next;
      op_reg       <= op_next;
      w_loaded_reg <= w_loaded_next;
      if (accept && (cmd_op == OP_FETCH || cmd_op == OP_FX)) begin
        addr_reg <= cmd_base_addr;
      end
      if (state_next == F_START || state_next == X_START) begin
        cnt_reg <= '0;
      end else if (state_reg == F_START || state_reg == F_WAIT ||
                   state_reg == X_START || state_reg == X_WAIT) begin
        cnt_reg <= cnt_reg + CW'(1);
      end
      cmd_ready_reg   <= (state_next == IDLE);
      fetch_start_reg <= (state_next == F_START);
      exec_start_reg  <= (state_next == X_START);
      bram_sel_reg    <= (state_next == F_START) || (state_next == F_WAIT);
      busy_reg        <= (state_next != IDLE);
      rsp_valid_reg   <= (state_next == RSP);
      rsp_err_reg     <= (state_next == RSP) ? err_next : ERR_OK;
    end
  end

  assign cmd_ready       = cmd_ready_reg;
  assign fetch_start     = fetch_start_reg;
  assign fetch_base_addr = addr_reg;
  assign exec_start      = exec_start_reg;
  assign bram_sel        = bram_sel_reg;
  assign w_loaded        = w_loaded_reg;
  assign busy            = busy_reg;
  assign rsp_valid       = rsp_valid_reg;
  assign rsp_err         = rsp_err_reg;

endmodule

// File: tb/tb_stmm_seq_ctrl.sv
// Directed bench for stmm_seq_ctrl: instance a uses the default watchdog,
// instance b uses TIMEOUT=16 for the timeout scenarios.
module tb_stmm_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // instance a (TIMEOUT default)
  logic        a_cmd_valid = 1'b0;
  logic [1:0]  a_cmd_op = 2'b00;
  logic [31:0] a_cmd_base = '0;
  logic        a_fetch_done = 1'b0;
  logic        a_exec_done = 1'b0;
  logic        a_cmd_ready, a_fetch_start, a_exec_start, a_bram_sel;
  logic        a_w_loaded, a_busy, a_rsp_valid;
  logic [31:0] a_fetch_addr;
  logic [1:0]  a_rsp_err;

  // instance b (TIMEOUT=16)
  logic        b_cmd_valid = 1'b0;
  logic [1:0]  b_cmd_op = 2'b00;
  logic [31:0] b_cmd_base = '0;
  logic        b_fetch_done = 1'b0;
  logic        b_exec_done = 1'b0;
  logic        b_cmd_ready, b_fetch_start, b_exec_start, b_bram_sel;
  logic        b_w_loaded, b_busy, b_rsp_valid;
  logic [31:0] b_fetch_addr;
  logic [1:0]  b_rsp_err;

  stmm_seq_ctrl #(.ADDR_W(32)) dut_a (
    .clk(clk), .rst(rst),
    .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready), .cmd_op(a_cmd_op),
    .cmd_base_addr(a_cmd_base), .fetch_start(a_fetch_start),
    .fetch_base_addr(a_fetch_addr), .fetch_done(a_fetch_done),
    .exec_start(a_exec_start), .exec_done(a_exec_done),
    .bram_sel(a_bram_sel), .w_loaded(a_w_loaded), .busy(a_busy),
    .rsp_valid(a_rsp_valid), .rsp_err(a_rsp_err)
  );

  stmm_seq_ctrl #(.ADDR_W(32), .TIMEOUT(16)) dut_b (
    .clk(clk), .rst(rst),
    .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready), .cmd_op(b_cmd_op),
    .cmd_base_addr(b_cmd_base), .fetch_start(b_fetch_start),
    .fetch_base_addr(b_fetch_addr), .fetch_done(b_fetch_done),
    .exec_start(b_exec_start), .exec_done(b_exec_done),
    .bram_sel(b_bram_sel), .w_loaded(b_w_loaded), .busy(b_busy),
    .rsp_valid(b_rsp_valid), .rsp_err(b_rsp_err)
  );

  // Running pulse counts for instance a.
  int a_fs_cnt = 0, a_xs_cnt = 0, a_rsp_cnt = 0;
  always @(posedge clk) begin
    a_fs_cnt  <= a_fs_cnt + int'(a_fetch_start);
    a_xs_cnt  <= a_xs_cnt + int'(a_exec_start);
    a_rsp_cnt <= a_rsp_cnt + int'(a_rsp_valid);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (a_cmd_ready !== 1'b0 || a_busy !== 1'b0 || a_rsp_valid !== 1'b0 || a_fetch_start !== 1'b0 || a_exec_start !== 1'b0 || a_bram_sel !== 1'b0) begin errors++; $display("FAIL reset_outputs: got rdy=%b busy=%b rsp=%b fs=%b xs=%b sel=%b want all 0", a_cmd_ready, a_busy, a_rsp_valid, a_fetch_start, a_exec_start, a_bram_sel); end
    checks++; if (a_w_loaded !== 1'b0 || a_fetch_addr !== 32'h0) begin errors++; $display("FAIL reset_state: got w_loaded=%b addr=%h want 0/0", a_w_loaded, a_fetch_addr); end
    rst = 1'b0;
    tick();
    checks++; if (a_cmd_ready !== 1'b1 || b_cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got a=%b b=%b want 1/1", a_cmd_ready, b_cmd_ready); end
    $display("txn reset done");
  endtask

  task automatic test_exec_no_weights();
    int xs0;
    xs0 = a_xs_cnt;
    a_cmd_op = 2'b10; a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    checks++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 2'b01) begin errors++; $display("FAIL exec_nw_rsp: got valid=%b err=%b want 1/01", a_rsp_valid, a_rsp_err); end
    checks++; if (a_exec_start !== 1'b0 || a_cmd_ready !== 1'b0) begin errors++; $display("FAIL exec_nw_rsp_cycle: got xs=%b rdy=%b want 0/0", a_exec_start, a_cmd_ready); end
    tick();
    checks++; if (a_rsp_valid !== 1'b0 || a_cmd_ready !== 1'b1 || a_xs_cnt != xs0) begin errors++; $display("FAIL exec_nw_after: got rsp=%b rdy=%b xs_pulses=%0d want 0/1/0", a_rsp_valid, a_cmd_ready, a_xs_cnt - xs0); end
    $display("txn EXEC without weights -> err=%b", 2'b01);
  endtask

  task automatic test_fetch();
    int sel_bad;
    sel_bad = 0;
    a_cmd_op = 2'b01; a_cmd_base = 32'h0000_1000; a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0; a_cmd_base = 32'hDEAD_BEEF;
    checks++; if (a_fetch_start !== 1'b1 || a_bram_sel !== 1'b1 || a_busy !== 1'b1) begin errors++; $display("FAIL fetch_start: got fs=%b sel=%b busy=%b want 1/1/1", a_fetch_start, a_bram_sel, a_busy); end
    checks++; if (a_fetch_addr !== 32'h0000_1000 || a_w_loaded !== 1'b0) begin errors++; $display("FAIL fetch_latch: got addr=%h wl=%b want 00001000/0", a_fetch_addr, a_w_loaded); end
    for (int i = 1; i < 20; i++) begin
      tick();
      if (a_bram_sel !== 1'b1 || a_fetch_start !== 1'b0 || a_rsp_valid !== 1'b0 || a_fetch_addr !== 32'h0000_1000) sel_bad++;
    end
    checks++; if (sel_bad != 0) begin errors++; $display("FAIL fetch_wait: got %0d bad wait cycles want 0", sel_bad); end
    tick();
    a_fetch_done = 1'b1;
    tick();
    a_fetch_done = 1'b0;
    checks++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 2'b00 || a_w_loaded !== 1'b1 || a_bram_sel !== 1'b0) begin errors++; $display("FAIL fetch_rsp: got valid=%b err=%b wl=%b sel=%b want 1/00/1/0", a_rsp_valid, a_rsp_err, a_w_loaded, a_bram_sel); end
    tick();
    checks++; if (a_cmd_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin errors++; $display("FAIL fetch_idle: got rdy=%b rsp=%b want 1/0", a_cmd_ready, a_rsp_valid); end
    $display("txn FETCH base=%h -> err=00", 32'h1000);
  endtask

  task automatic test_exec_twice();
    for (int n = 0; n < 2; n++) begin
      a_cmd_op = 2'b10; a_cmd_valid = 1'b1;
      tick();
      a_cmd_valid = 1'b0;
      checks++; if (a_exec_start !== 1'b1 || a_bram_sel !== 1'b0 || a_w_loaded !== 1'b1) begin errors++; $display("FAIL exec%0d_start: got xs=%b sel=%b wl=%b want 1/0/1", n, a_exec_start, a_bram_sel, a_w_loaded); end
      for (int i = 0; i < 10; i++) tick();
      a_exec_done = 1'b1;
      tick();
      a_exec_done = 1'b0;
      checks++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 2'b00 || a_w_loaded !== 1'b1) begin errors++; $display("FAIL exec%0d_rsp: got valid=%b err=%b wl=%b want 1/00/1", n, a_rsp_valid, a_rsp_err, a_w_loaded); end
      tick();
      $display("txn EXEC #%0d -> err=00", n);
    end
  endtask

  task automatic test_fetch_exec();
    int fs0, xs0, r0;
    fs0 = a_fs_cnt; xs0 = a_xs_cnt; r0 = a_rsp_cnt;
    a_cmd_op = 2'b11; a_cmd_base = 32'h0000_2000; a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    a_fetch_done = 1'b1;  // completes in the F_START cycle
    tick();
    a_fetch_done = 1'b0;
    checks++; if (a_exec_start !== 1'b1 || a_w_loaded !== 1'b1 || a_rsp_valid !== 1'b0 || a_fetch_addr !== 32'h0000_2000) begin errors++; $display("FAIL fx_exec_start: got xs=%b wl=%b rsp=%b addr=%h want 1/1/0/00002000", a_exec_start, a_w_loaded, a_rsp_valid, a_fetch_addr); end
    tick();
    a_exec_done = 1'b1;
    tick();
    a_exec_done = 1'b0;
    checks++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 2'b00) begin errors++; $display("FAIL fx_rsp: got valid=%b err=%b want 1/00", a_rsp_valid, a_rsp_err); end
    tick();
    checks++; if (a_fs_cnt - fs0 != 1 || a_xs_cnt - xs0 != 1 || a_rsp_cnt - r0 != 1) begin errors++; $display("FAIL fx_pulse_counts: got fs=%0d xs=%0d rsp=%0d want 1/1/1", a_fs_cnt - fs0, a_xs_cnt - xs0, a_rsp_cnt - r0); end
    $display("txn FETCH_EXEC base=%h -> err=00", 32'h2000);
  endtask

  task automatic test_timeout();
    // fetch phase expiry with no done
    b_cmd_op = 2'b01; b_cmd_base = 32'h0000_3000; b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++; if (b_rsp_valid !== 1'b0 || b_busy !== 1'b1) begin errors++; $display("FAIL tmo_f_early: got rsp=%b busy=%b want 0/1", b_rsp_valid, b_busy); end
    tick();
    checks++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 2'b10 || b_w_loaded !== 1'b0) begin errors++; $display("FAIL tmo_f_rsp: got valid=%b err=%b wl=%b want 1/10/0", b_rsp_valid, b_rsp_err, b_w_loaded); end
    tick();
    $display("txn FETCH timeout -> err=10");
    // done on the expiry cycle wins
    b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    b_fetch_done = 1'b1;
    tick();
    b_fetch_done = 1'b0;
    checks++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 2'b00 || b_w_loaded !== 1'b1) begin errors++; $display("FAIL tmo_f_done_wins: got valid=%b err=%b wl=%b want 1/00/1", b_rsp_valid, b_rsp_err, b_w_loaded); end
    tick();
    $display("txn FETCH done at expiry -> err=00");
    // exec phase expiry keeps weights
    b_cmd_op = 2'b10; b_cmd_valid = 1'b1;
    tick();
    b_cmd_valid = 1'b0;
    for (int i = 0; i < 16; i++) tick();
    checks++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 2'b11 || b_w_loaded !== 1'b1) begin errors++; $display("FAIL tmo_x_rsp: got valid=%b err=%b wl=%b want 1/11/1", b_rsp_valid, b_rsp_err, b_w_loaded); end
    tick();
    $display("txn EXEC timeout -> err=11");
  endtask

  task automatic test_reset_mid_and_stray();
    int r0;
    a_cmd_op = 2'b10; a_cmd_valid = 1'b1;
    tick();
    a_cmd_valid = 1'b0;
    tick();  // X_WAIT
    checks++; if (a_busy !== 1'b1 || a_exec_start !== 1'b0) begin errors++; $display("FAIL mid_xwait: got busy=%b xs=%b want 1/0", a_busy, a_exec_start); end
    rst = 1'b1;
    tick();
    checks++; if (a_busy !== 1'b0 || a_w_loaded !== 1'b0 || a_rsp_valid !== 1'b0 || a_fetch_addr !== 32'h0 || a_bram_sel !== 1'b0) begin errors++; $display("FAIL mid_reset: got busy=%b wl=%b rsp=%b addr=%h sel=%b want 0/0/0/0/0", a_busy, a_w_loaded, a_rsp_valid, a_fetch_addr, a_bram_sel); end
    rst = 1'b0;
    tick();
    r0 = a_rsp_cnt;
    a_exec_done = 1'b1; a_fetch_done = 1'b1;
    tick(); tick();
    a_exec_done = 1'b0; a_fetch_done = 1'b0;
    tick();
    checks++; if (a_rsp_cnt != r0 || a_busy !== 1'b0 || a_w_loaded !== 1'b0 || a_cmd_ready !== 1'b1) begin errors++; $display("FAIL stray_pulses: got rsps=%0d busy=%b wl=%b rdy=%b want 0/0/0/1", a_rsp_cnt - r0, a_busy, a_w_loaded, a_cmd_ready); end
    $display("txn reset in X_WAIT and stray done pulses ignored");
  endtask

  initial begin
    test_reset();
    test_exec_no_weights();
    test_fetch();
    test_exec_twice();
    test_fetch_exec();
    test_timeout();
    test_reset_mid_and_stray();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stmm_seq_ctrl.md
Name: stmm_seq_ctrl

Overview:
- Command-level sequencer for the StMM execution unit.
- Accepts one command at a time (weight fetch, matmul execute, or both back to back) and drives the parameter fetcher and StMM core with one-cycle start pulses.
- Owns the weight-BRAM write/read port select and tracks whether the BRAM holds valid weights.
- Returns a single response pulse with an error code; a per-phase watchdog ensures a stalled phase always terminates.

Parameters:
- ADDR_W, 32, width of the SDRAM base address for the weight fetch.
- TIMEOUT, 4096, watchdog limit in cycles per wait phase; 0 disables the watchdog.
- CNT_W, $clog2(TIMEOUT+1), watchdog counter width (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 NOP, 01 FETCH, 10 EXEC, 11 FETCH_EXEC.
- cmd_base_addr  in  ADDR_W  SDRAM base address of the weights (FETCH and FETCH_EXEC only).
- fetch_start  out  1  one-cycle start pulse to the parameter fetcher.
- fetch_base_addr  out  ADDR_W  latched base address; stable for the whole fetch.
- fetch_done  in  1  fetcher completion pulse.
- exec_start  out  1  one-cycle start pulse to StMM.
- exec_done  in  1  StMM out_valid completion pulse.
- bram_sel  out  1  1 = fetcher owns the BRAM address/write port; 0 = StMM owns it.
- w_loaded  out  1  BRAM holds a complete weight set.
- busy  out  1  state != IDLE.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  2  00 OK, 01 EXEC with no weights, 10 fetch timeout, 11 exec timeout; valid only with rsp_valid.

Behaviour:
- States: IDLE, F_START, F_WAIT, X_START, X_WAIT, RSP. All outputs are registered, Moore-style.
- Reset (synchronous, wins over every other event, including mid-operation): state=IDLE, w_loaded=0, all other outputs 0, fetch_base_addr=0, watchdog counter=0.
- cmd_ready=1 only in IDLE. A command is accepted when cmd_valid && cmd_ready. cmd_op and cmd_base_addr are latched on accept.
- NOP: IDLE -> RSP, rsp_err=00.
- FETCH / FETCH_EXEC:
  - On accept: clear w_loaded and latch fetch_base_addr, then -> F_START.
  - F_START: fetch_start=1 for exactly one cycle, then -> F_WAIT.
  - bram_sel=1 throughout F_START and F_WAIT.
- EXEC:
  - w_loaded=0 at accept: -> RSP with rsp_err=01; no exec_start is issued.
  - Otherwise -> X_START.
- X_START: exec_start=1 for one cycle, then -> X_WAIT. bram_sel=0.
- fetch_done is honoured in F_START or F_WAIT. On fetch_done:
  - set w_loaded=1;
  - if the latched op is FETCH -> RSP with rsp_err=00;
  - if FETCH_EXEC -> X_START.
- exec_done is honoured in X_START or X_WAIT; on it -> RSP with rsp_err=00.
- Done pulses arriving in any other state are ignored, with no state or flag change.
- Watchdog (when TIMEOUT != 0):
  - Counter clears on entry to F_START and X_START and increments every cycle in the START/WAIT states.
  - When the counter reaches TIMEOUT-1 with no done: -> RSP with rsp_err=10 (fetch phase, w_loaded stays 0) or 11 (exec phase, w_loaded unchanged).
  - If done and timeout occur in the same cycle, done wins.
- RSP: rsp_valid=1 for one cycle, then -> IDLE. cmd_ready returns to 1 the cycle after RSP.
- Latency:
  - Accept at cycle T -> start pulse at T+1.
  - Done at cycle D -> rsp_valid at D+1.
  - FETCH_EXEC: fetch_done at D -> exec_start at D+1.
- w_loaded persists across EXEC commands; only reset, a new FETCH/FETCH_EXEC accept, or a fetch timeout affects it.

Test Plan:
- Reset, then EXEC (cmd_op=10) -> rsp_valid at T+1 with rsp_err=01; exec_start never asserted.
- FETCH with base 0x0000_1000, fetch_done 20 cycles after fetch_start -> fetch_base_addr=0x1000; bram_sel=1 in F_START/F_WAIT; rsp_err=00 at D+1; w_loaded=1.
- Then EXEC twice, exec_done 10 cycles after each exec_start -> two responses with rsp_err=00; bram_sel=0; w_loaded stays 1.
- FETCH_EXEC with fetch_done asserted in the F_START cycle -> exec_start the next cycle; single rsp_valid after exec_done; exactly one fetch_start and one exec_start.
- TIMEOUT=16, FETCH with no fetch_done -> rsp_err=10 sixteen cycles after F_START entry; w_loaded=0. Repeat with fetch_done on the expiry cycle -> rsp_err=00.
- Assert rst in X_WAIT; also drive stray exec_done/fetch_done in IDLE -> after reset, IDLE with w_loaded=0 and outputs 0; stray pulses cause no response.
